display_arbiter: RTL and testbench

DISPLAY_ARBITER -- requirements
Module: display_arbiter

---
 rtl/display_pkg.sv | 13 +
 rtl/rr_picker.sv | 32 +++
 rtl/display_arbiter.sv | 116 +++++++++++
 tb/tb_display_arbiter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and defaults for the hex-display arbiter.
// Holds the two-state FSM encoding and the power-on parameter defaults.
package display_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_HOLD_CYCLES = 50_000_000;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set request at or after start_i, wrapping.
// Zero latency; found_o low and winner_o zero when no request is set.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  output logic          found_o,
  output logic [IW-1:0] winner_o
);

  logic [N-1:0] rot;
  logic [IW:0]  sum;

  // Rotate so that bit 0 corresponds to the start index.
  assign rot = N'({req_i, req_i} >> start_i);

  always_comb begin
    found_o  = 1'b0;
    winner_o = '0;
    sum      = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found_o  = 1'b1;
        sum      = {1'b0, start_i} + (IW + 1)'(k);
        winner_o = (sum >= (IW + 1)'(N)) ? IW'(sum - (IW + 1)'(N)) : sum[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/display_arbiter.sv
// Round-robin owner of the shared 8-digit hex display with minimum dwell, lock and early release.
// Grant/owner/valid update one edge after the decision; val_out tracks the owner's value one cycle late.
module display_arbiter
  import display_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic [NUM_REQ-1:0]         req_in,
  input  logic [NUM_REQ*32-1:0]      val_in,
  input  logic                       lock_in,
  output logic [31:0]                val_out,
  output logic [NUM_REQ-1:0]         grant_out,
  output logic [$clog2(NUM_REQ)-1:0] owner_out,
  output logic                       valid_out
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_REQ - 1);
  localparam logic [31:0]   EXPIRE_CNT = 32'(HOLD_CYCLES - 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [31:0]     cnt_q,   cnt_d;
  logic [31:0]     val_q,   val_d;

  logic [31:0]     val_arr [NUM_REQ];
  logic [IW-1:0]   start_idx;
  logic            found;
  logic [IW-1:0]   winner;
  logic            expire;
  logic            early_rel;
  logic            rearb;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_val
    assign val_arr[g] = val_in[32*g +: 32];
  end

  // Search always starts just after the last owner, so the current owner is considered last.
  assign start_idx = (owner_q == LAST_IDX) ? '0 : owner_q + IW'(1);
  assign expire    = (cnt_q == EXPIRE_CNT);
  assign early_rel = ~req_in[owner_q];
  assign rearb     = early_rel | (expire & ~lock_in);

  rr_picker #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_picker (
    .req_i    (req_in),
    .start_i  (start_idx),
    .found_o  (found),
    .winner_o (winner)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = HOLD;
          owner_d = winner;
          cnt_d   = '0;
          val_d   = val_arr[winner];
        end
      end
      HOLD: begin
        if (rearb) begin
          cnt_d = '0;
          if (found) begin
            owner_d = winner;
            val_d   = val_arr[winner];
          end else begin
            state_d = IDLE;
          end
        end else begin
          // A locked grant parks the counter at expiry until the lock is released.
          cnt_d = expire ? cnt_q : cnt_q + 32'd1;
          val_d = val_arr[owner_q];
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      owner_q <= LAST_IDX;
      cnt_q   <= '0;
      val_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
    end
  end

  assign valid_out = (state_q == HOLD);
  assign grant_out = valid_out ? (NUM_REQ'(1) << owner_q) : '0;
  assign owner_out = owner_q;
  assign val_out   = val_q;

  a_grant_onehot0 : assert property (@(posedge clk_in) $onehot0(grant_out));
  a_valid_grant   : assert property (@(posedge clk_in) valid_out == (|grant_out));
  a_cnt_bound     : assert property (@(posedge clk_in) cnt_q <= EXPIRE_CNT);

endmodule

// File: tb/tb_display_arbiter.sv
// Directed and randomized checks of display_arbiter against a cycle-level reference model.
// Inputs change 1 time unit after each rising edge; outputs are compared at the same point.
module tb_display_arbiter;

  localparam int NR = 4;
  localparam int HC = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR-1:0] req;
  logic [NR*32-1:0] vals;
  logic          lock;
  logic [31:0]   val_o;
  logic [NR-1:0] grant;
  logic [1:0]    owner;
  logic          valid;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_valid;
  int          m_owner;
  int          m_cnt;
  logic [31:0] m_val;

  always #5 clk = ~clk;

  display_arbiter #(
    .NUM_REQ     (NR),
    .HOLD_CYCLES (HC)
  ) dut (
    .clk_in    (clk),
    .rst_in    (rst_n),
    .req_in    (req),
    .val_in    (vals),
    .lock_in   (lock),
    .val_out   (val_o),
    .grant_out (grant),
    .owner_out (owner),
    .valid_out (valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] val_of(input int i);
    logic [NR*32-1:0] v;
    v = vals;
    return v[32*i +: 32];
  endfunction

  task automatic setv(input int i, input logic [31:0] v);
    vals[32*i +: 32] = v;
  endtask

  // Next requester after 'after' in circular order, 'after' itself last; -1 if none.
  function automatic int next_req(input int after, input logic [NR-1:0] r);
    for (int k = 1; k <= NR; k++) begin
      int idx;
      idx = (after + k) % NR;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_edge();
    int w;
    if (!rst_n) begin
      m_valid = 0; m_owner = NR - 1; m_cnt = 0; m_val = 32'h0;
    end else if (!m_valid || !req[m_owner] || (m_cnt == HC - 1 && !lock)) begin
      w = next_req(m_owner, req);
      m_cnt = 0;
      if (w >= 0) begin
        m_valid = 1; m_owner = w; m_val = val_of(w);
      end else begin
        m_valid = 0;
      end
    end else begin
      if (m_cnt < HC - 1) m_cnt++;
      m_val = val_of(m_owner);
    end
  endtask

  task automatic cyc(input string tag);
    logic [NR-1:0] eg;
    model_edge();
    @(posedge clk);
    #1;
    eg = m_valid ? NR'(1 << m_owner) : '0;
    chk({tag, ".grant"}, 32'(grant), 32'(eg));
    chk({tag, ".owner"}, 32'(owner), 32'(m_owner));
    chk({tag, ".valid"}, 32'(valid), 32'(m_valid));
    chk({tag, ".val"},   val_o,      m_val);
  endtask

  initial begin
    rst_n = 1'b0; req = '0; lock = 1'b0; vals = '0;
    m_valid = 0; m_owner = NR - 1; m_cnt = 0; m_val = 32'h0;
    @(posedge clk); #1;
    cyc("rst");
    chk("rst.owner_c", 32'(owner), 32'd3);
    chk("rst.grant_c", 32'(grant), 32'd0);
    rst_n = 1'b1;
    cyc("idle");

    // Two requesters alternate after each full dwell
    setv(0, 32'h1111_1111); setv(2, 32'h2222_2222); setv(1, 32'h3333_3333);
    req = 4'b0101;
    cyc("rr.g0");
    chk("rr.g0_c", 32'(grant), 32'h1);
    cyc("rr.v0");
    chk("rr.v0_c", val_o, 32'h1111_1111);
    repeat (3) cyc("rr.dw0");
    chk("rr.g2_c", 32'(grant), 32'h4);
    chk("rr.v2_c", val_o, 32'h2222_2222);
    repeat (4) cyc("rr.dw2");
    chk("rr.back_c", 32'(grant), 32'h1);

    // Sole requester keeps being re-granted
    req = 4'b1000;
    cyc("solo.take");
    for (int i = 0; i < 12; i++) begin
      cyc("solo");
      chk("solo.grant_c", 32'(grant), 32'h8);
      chk("solo.valid_c", 32'(valid), 32'h1);
    end

    // Lock holds owner 0 past expiry, release hands over on next edge
    req = 4'b0001;
    cyc("lk.own0");
    lock = 1'b1; req = 4'b0011;
    for (int i = 0; i < 10; i++) begin
      cyc("lk.hold");
      chk("lk.grant_c", 32'(grant), 32'h1);
    end
    lock = 1'b0;
    cyc("lk.rel");
    chk("lk.rel_c", 32'(grant), 32'h2);

    // Early release with nobody waiting drops to idle, value held
    cyc("er.mid");
    req = 4'b0000;
    cyc("er.idle");
    chk("er.grant_c", 32'(grant), 32'h0);
    chk("er.valid_c", 32'(valid), 32'h0);
    chk("er.val_c", val_o, 32'h3333_3333);
    cyc("er.stay");

    // Reset mid-hold, then requester 0 wins first
    req = 4'b0001;
    cyc("rh.g");
    cyc("rh.h");
    rst_n = 1'b0; req = 4'b0011;
    cyc("rh.rst");
    chk("rh.owner_c", 32'(owner), 32'd3);
    chk("rh.val_c", val_o, 32'h0);
    rst_n = 1'b1;
    cyc("rh.first");
    chk("rh.first_c", 32'(grant), 32'h1);

    // Live value tracking of the owner
    setv(0, 32'hDEAD_BEEF);
    cyc("live.a");
    chk("live.a_c", val_o, 32'hDEAD_BEEF);
    setv(0, 32'hCAFE_F00D);
    cyc("live.b");
    chk("live.b_c", val_o, 32'hCAFE_F00D);
    chk("live.g_c", 32'(grant), 32'h1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) req = NR'($urandom_range(0, 15));
      lock  = ($urandom_range(0, 3) == 0);
      rst_n = ($urandom_range(0, 79) != 0);
      setv(int'($urandom_range(0, NR - 1)), $urandom);
      cyc("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
